// File: rtl/entity_row_fetch_scheduler.sv
// Per-scanline sprite row fetcher: during hblank it scans the nine entity slots, fetches one
// 8-pixel sprite row per hit over a shared ROM port, and double-buffers the rows for the renderer.
module entity_row_fetch_scheduler #(
  parameter int H_ACTIVE  = 640,
  parameter int H_TOTAL   = 800,
  parameter int V_ACTIVE  = 480,
  parameter int V_TOTAL   = 525,
  parameter int TILE_PX   = 40,
  parameter int SCALE     = 5,
  parameter int NUM_SLOTS = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [9:0]              counter_H,
  input  logic [9:0]              counter_V,
  input  logic [14*NUM_SLOTS-1:0] entities,
  output logic                    rom_req,
  output logic [6:0]              rom_addr,
  input  logic                    rom_ack,
  input  logic [7:0]              rom_data,
  input  logic [3:0]              rd_slot,
  output logic                    rd_valid,
  output logic [3:0]              rd_col,
  output logic [1:0]              rd_orient,
  output logic [7:0]              rd_data,
  output logic                    overrun
);

  // ROM handshake: rom_req rises with rom_addr latched and both hold until a cycle with
  // rom_ack=1; that cycle is the transfer and rom_req falls on the next edge. A line swap
  // withdraws rom_req and any ack arriving in the swap cycle is discarded.
  typedef enum logic [1:0] {IDLE, SCAN, FETCH, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] slot_q, slot_d;
  logic       rom_req_q, rom_req_d;
  logic [6:0] rom_addr_q, rom_addr_d;
  logic [3:0] cur_col_q, cur_col_d;
  logic [1:0] cur_or_q, cur_or_d;

  logic [3:0] tile_row_q, tile_row_d;
  logic [2:0] spr_row_q, spr_row_d;
  logic [2:0] scale_cnt_q, scale_cnt_d;
  logic       next_vis_q, next_vis_d;

  logic       back_valid_q  [NUM_SLOTS];
  logic [3:0] back_col_q    [NUM_SLOTS];
  logic [1:0] back_or_q     [NUM_SLOTS];
  logic [7:0] back_data_q   [NUM_SLOTS];
  logic       front_valid_q [NUM_SLOTS];
  logic [3:0] front_col_q   [NUM_SLOTS];
  logic [1:0] front_or_q    [NUM_SLOTS];
  logic [7:0] front_data_q  [NUM_SLOTS];

  logic [13:0] desc_a [NUM_SLOTS];
  logic [13:0] desc;
  logic        line_start, swap, hit, last_slot;
  logic        clear_back, write_back;

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_desc
    assign desc_a[k] = entities[14*k +: 14];
  end

  assign line_start = (counter_H == 10'(H_ACTIVE));
  assign swap       = (counter_H == 10'(H_TOTAL - 1));
  assign desc       = (slot_q < 4'(NUM_SLOTS)) ? desc_a[slot_q] : '1;
  assign hit        = (desc[13:10] != 4'hF) && (desc[3:0] == tile_row_q);
  assign last_slot  = (slot_q == 4'(NUM_SLOTS - 1));

  // Trackers step once per line to describe line counter_V+1, using wrap counters
  // instead of dividing the line number by TILE_PX and SCALE.
  always_comb begin
    tile_row_d  = tile_row_q;
    spr_row_d   = spr_row_q;
    scale_cnt_d = scale_cnt_q;
    next_vis_d  = next_vis_q;
    if (line_start) begin
      if (counter_V == 10'(V_TOTAL - 1)) begin
        tile_row_d  = '0;
        spr_row_d   = '0;
        scale_cnt_d = '0;
        next_vis_d  = 1'b1;
      end else if (counter_V >= 10'(V_ACTIVE - 1)) begin
        next_vis_d = 1'b0;
      end else begin
        next_vis_d = 1'b1;
        if (scale_cnt_q == 3'(SCALE - 1)) begin
          scale_cnt_d = '0;
          spr_row_d   = spr_row_q + 3'd1;
          if (spr_row_q == 3'(TILE_PX / SCALE - 1)) begin
            tile_row_d = tile_row_q + 4'd1;
          end
        end else begin
          scale_cnt_d = scale_cnt_q + 3'd1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    rom_req_d  = rom_req_q;
    rom_addr_d = rom_addr_q;
    cur_col_d  = cur_col_q;
    cur_or_d   = cur_or_q;
    clear_back = 1'b0;
    write_back = 1'b0;
    overrun    = 1'b0;
    case (state_q)
      IDLE: begin
        if (line_start) begin
          clear_back = 1'b1;
          slot_d     = '0;
          state_d    = next_vis_d ? SCAN : DONE;
        end
      end
      SCAN: begin
        if (hit) begin
          rom_addr_d = {desc[13:10], spr_row_q ^ {3{desc[9]}}};
          cur_col_d  = desc[7:4];
          cur_or_d   = desc[9:8];
          rom_req_d  = 1'b1;
          state_d    = FETCH;
        end else if (last_slot) begin
          state_d = DONE;
        end else begin
          slot_d = slot_q + 4'd1;
        end
      end
      FETCH: begin
        if (rom_ack) begin
          write_back = 1'b1;
          rom_req_d  = 1'b0;
          if (last_slot) begin
            state_d = DONE;
          end else begin
            slot_d  = slot_q + 4'd1;
            state_d = SCAN;
          end
        end
      end
      default: ;
    endcase
    if (swap) begin
      overrun    = (state_q == SCAN) || (state_q == FETCH);
      state_d    = IDLE;
      rom_req_d  = 1'b0;
      write_back = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      rom_req_q   <= 1'b0;
      rom_addr_q  <= '0;
      cur_col_q   <= '0;
      cur_or_q    <= '0;
      tile_row_q  <= '0;
      spr_row_q   <= '0;
      scale_cnt_q <= '0;
      next_vis_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      rom_req_q   <= rom_req_d;
      rom_addr_q  <= rom_addr_d;
      cur_col_q   <= cur_col_d;
      cur_or_q    <= cur_or_d;
      tile_row_q  <= tile_row_d;
      spr_row_q   <= spr_row_d;
      scale_cnt_q <= scale_cnt_d;
      next_vis_q  <= next_vis_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        back_valid_q[k]  <= 1'b0;
        back_col_q[k]    <= '0;
        back_or_q[k]     <= '0;
        back_data_q[k]   <= '0;
        front_valid_q[k] <= 1'b0;
        front_col_q[k]   <= '0;
        front_or_q[k]    <= '0;
        front_data_q[k]  <= '0;
      end
    end else begin
      if (swap) begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
          front_valid_q[k] <= back_valid_q[k];
          front_col_q[k]   <= back_col_q[k];
          front_or_q[k]    <= back_or_q[k];
          front_data_q[k]  <= back_data_q[k];
        end
      end
      if (clear_back) begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
          back_valid_q[k] <= 1'b0;
        end
      end else if (write_back) begin
        back_valid_q[slot_q] <= 1'b1;
        back_col_q[slot_q]   <= cur_col_q;
        back_or_q[slot_q]    <= cur_or_q;
        back_data_q[slot_q]  <= rom_data;
      end
    end
  end

  assign rom_req  = rom_req_q;
  assign rom_addr = rom_addr_q;

  // Invalid entries read as zero so stale column/data never leak to the renderer.
  always_comb begin
    rd_valid  = 1'b0;
    rd_col    = '0;
    rd_orient = '0;
    rd_data   = '0;
    if (rd_slot < 4'(NUM_SLOTS)) begin
      if (front_valid_q[rd_slot]) begin
        rd_valid  = 1'b1;
        rd_col    = front_col_q[rd_slot];
        rd_orient = front_or_q[rd_slot];
        rd_data   = front_data_q[rd_slot];
      end
    end
  end

endmodule

// File: tb/tb_entity_row_fetch_scheduler.sv
// Directed bench for entity_row_fetch_scheduler: a ROM responder checks request addresses
// against an expected queue; front-buffer contents are checked after each swap.
module tb_entity_row_fetch_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [9:0]   counter_H, counter_V;
  logic [125:0] entities;
  logic         rom_req, rom_ack;
  logic [6:0]   rom_addr;
  logic [7:0]   rom_data;
  logic [3:0]   rd_slot;
  logic         rd_valid, overrun;
  logic [3:0]   rd_col;
  logic [1:0]   rd_orient;
  logic [7:0]   rd_data;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int rom_lat   = 2;

  logic [6:0]  exp_q[$];
  logic [3:0]  e_id[9], e_col[9], e_row[9];
  logic [1:0]  e_or[9];
  logic [14:0] exp_front[9];

  always #5 clk = ~clk;

  entity_row_fetch_scheduler dut (
    .clk(clk), .rst_n(rst_n), .counter_H(counter_H), .counter_V(counter_V),
    .entities(entities), .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack),
    .rom_data(rom_data), .rd_slot(rd_slot), .rd_valid(rd_valid), .rd_col(rd_col),
    .rd_orient(rd_orient), .rd_data(rd_data), .overrun(overrun)
  );

  function automatic logic [7:0] rom_fn(input logic [6:0] a);
    return {a, 1'b0} ^ 8'hA5;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic clear_ents();
    for (int k = 0; k < 9; k++) begin
      e_id[k] = 4'hF; e_or[k] = 2'd0; e_col[k] = 4'd0; e_row[k] = 4'd0;
    end
  endtask

  task automatic set_ent(input int k, input int id, input int orient, input int col, input int row);
    e_id[k] = 4'(id); e_or[k] = 2'(orient); e_col[k] = 4'(col); e_row[k] = 4'(row);
  endtask

  task automatic apply_ents();
    for (int k = 0; k < 9; k++) entities[14*k +: 14] = {e_id[k], e_or[k], e_col[k], e_row[k]};
  endtask

  // Reads slots 0..9 (9 is out of range and must read zero), one slot per cycle.
  task automatic check_front(input string tag);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rd_slot = 4'(k);
      #1;
      check($sformatf("%s_rd%0d", tag, k), {rd_valid, rd_col, rd_orient, rd_data},
            (k < 9) ? exp_front[k] : 15'd0);
    end
  endtask

  task automatic fast_line(input int v);
    counter_V = 10'(v);
    @(negedge clk); counter_H = 10'd640;
    repeat (10) begin @(negedge clk); counter_H = 10'd641; end
    @(negedge clk); counter_H = 10'd799;
    @(negedge clk); counter_H = 10'd0;
  endtask

  // Model: next line's tile/sprite rows from the line number, and a cycle schedule where a
  // miss costs one cycle and a hit costs one scan cycle plus rom_lat fetch cycles.
  task automatic run_line(input int v, input string tag);
    int line, tile, spr, t;
    bit vis, done_all;
    logic [6:0] a;
    line = (v == 524) ? 0 : v + 1;
    vis  = (line < 480);
    tile = line / 40;
    spr  = (line % 40) / 5;
    for (int k = 0; k < 9; k++) exp_front[k] = '0;
    done_all = 1'b1;
    t = 641;
    if (vis) begin
      for (int k = 0; k < 9; k++) begin
        if (t > 798) begin done_all = 1'b0; break; end
        if (e_id[k] != 4'hF && e_row[k] == 4'(tile)) begin
          a = {e_id[k], 3'(spr) ^ {3{e_or[k][1]}}};
          exp_q.push_back(a);
          if (t + rom_lat > 798) begin done_all = 1'b0; break; end
          exp_front[k] = {1'b1, e_col[k], e_or[k], rom_fn(a)};
          t = t + rom_lat + 1;
        end else begin
          t = t + 1;
        end
      end
    end
    counter_V = 10'(v);
    apply_ents();
    for (int h = 640; h < 800; h++) begin
      @(negedge clk);
      counter_H = 10'(h);
      if (h == 798) begin #1; check({tag, "_overrun_798"}, overrun, 0); end
    end
    #1;
    check({tag, "_overrun_799"}, overrun, done_all ? 0 : 1);
    @(negedge clk);
    counter_H = 10'd0;
    #1;
    check({tag, "_req_after_swap"}, rom_req, 0);
    check({tag, "_overrun_clear"}, overrun, 0);
    check({tag, "_sb_left"}, exp_q.size(), 0);
    exp_q.delete();
    check_front(tag);
  endtask

  // ROM responder: acks rom_lat cycles after a request appears; first sight pops the scoreboard.
  initial begin
    int cnt;
    logic [6:0] a;
    rom_ack = 1'b0; rom_data = '0; cnt = 0;
    forever begin
      @(negedge clk);
      rom_ack = 1'b0;
      if (!rst_n || !rom_req) begin
        cnt = 0;
      end else begin
        if (cnt == 0) begin
          if (exp_q.size() == 0) check("rom_req_unexpected", exp_q.size(), 1);
          else begin
            a = exp_q.pop_front();
            check("rom_addr", rom_addr, a);
          end
        end
        cnt++;
        if (cnt == rom_lat) begin
          rom_ack  = 1'b1;
          rom_data = rom_fn(rom_addr);
        end
      end
    end
  end

  initial begin
    int req_seen;
    rst_n = 1'b0; counter_H = '0; counter_V = '0; rd_slot = '0;
    clear_ents(); apply_ents();
    for (int k = 0; k < 9; k++) exp_front[k] = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_rom_req", rom_req, 0);
    check("reset_rom_addr", rom_addr, 0);
    check("reset_overrun", overrun, 0);
    check_front("reset");
    @(negedge clk); #2 rst_n = 1'b1;

    // Empty slots: no requests, front stays empty.
    run_line(0, "empty");
    for (int v = 1; v < 44; v++) fast_line(v);

    // Single hit, line 45: tile_row 1, spr_row 1.
    rom_lat = 2;
    set_ent(3, 2, 0, 5, 1);
    run_line(44, "slot3");
    // Line 46 is still spr_row 1; orientation 2 flips it to 6.
    set_ent(3, 2, 2, 5, 1);
    run_line(45, "slot3_flip");

    // All nine hit with a slow ROM: scan cannot finish before the swap.
    rom_lat = 20;
    for (int k = 0; k < 9; k++) set_ent(k, k, k % 4, k + 3, 1);
    run_line(46, "overrun");

    clear_ents(); apply_ents();
    for (int v = 47; v < 478; v++) fast_line(v);

    // Last visible line 479 (tile 11, spr 7), then invisible line 480.
    rom_lat = 3;
    set_ent(2, 9, 1, 4, 11);
    set_ent(7, 14, 3, 12, 11);
    run_line(478, "line479");
    run_line(479, "line480");

    clear_ents(); apply_ents();
    for (int v = 480; v < 524; v++) fast_line(v);

    // Frame wrap: line 0 uses tile_row 0, spr_row 0.
    rom_lat = 4;
    set_ent(0, 1, 3, 2, 0);
    set_ent(4, 5, 0, 6, 5);
    set_ent(8, 12, 0, 15, 0);
    run_line(524, "line0");

    // Asynchronous reset during a fetch.
    clear_ents();
    set_ent(0, 6, 0, 9, 0);
    apply_ents();
    counter_V = 10'd0;
    rom_lat = 50;
    exp_q.push_back({4'd6, 3'd0});
    for (int h = 640; h <= 660; h++) begin @(negedge clk); counter_H = 10'(h); end
    #1 check("req_before_reset", rom_req, 1);
    #1 rst_n = 1'b0;
    #1;
    check("req_async_reset", rom_req, 0);
    check("addr_async_reset", rom_addr, 0);
    for (int k = 0; k < 9; k++) exp_front[k] = '0;
    check_front("mid_reset");
    @(negedge clk); #2 rst_n = 1'b1;
    req_seen = 0;
    for (int h = 661; h < 1440; h++) begin
      @(negedge clk);
      counter_H = 10'(h % 800);
      #1;
      if (rom_req) req_seen++;
    end
    check("no_req_after_reset", req_seen, 0);
    check("sb_after_reset", exp_q.size(), 0);

    // Scheduling resumes at the next line start (line 2: tile 0, spr 0).
    rom_lat = 3;
    run_line(1, "resume");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
